picosoc_bram: RTL
=================

PICOSOC_BRAM -- requirements
Module: picosoc_bram

Interface
REQ-001 The block SHALL have parameter WORDS, default 256: number of memory words; 2 or more, power of two not required.
REQ-002 The block SHALL have parameter BYTES, default 4: byte lanes per word; data width is 8*BYTES.
REQ-003 The block SHALL have parameter ADDR_W, default 22: width of the word address.
REQ-004 The block SHALL have parameter WAIT_STATES, default 0: extra cycles inserted before response; range 0..7.
REQ-005 The block SHALL have parameter CLEAR_ON_RESET, default 0: when 1, all words are zeroed by a sweep after reset.
REQ-006 The block SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 The block SHALL have port mem_valid  in  1  request present; held by master until mem_ready.
REQ-009 The block SHALL have port mem_addr  in  ADDR_W  word address, stable while mem_valid.
REQ-010 The block SHALL have port mem_wstrb  in  BYTES  per-lane write enables; all zero = read.
REQ-011 The block SHALL have port mem_wdata  in  8*BYTES  write data, lane i = bits [8i+7:8i].
REQ-012 The block SHALL have port mem_ready  out  1  one-cycle response strobe.
REQ-013 The block SHALL have port mem_rdata  out  8*BYTES  read data, valid while mem_ready.
REQ-014 The block SHALL have port mem_err  out  1  out-of-range flag, valid while mem_ready.
REQ-015 The block SHALL have port busy  out  1  high while the clear sweep runs.

Function
REQ-016 The FSM SHALL have states CLEAR, IDLE, WAIT and RESP.
REQ-017 CLEAR: write all-zero to word clr_idx each cycle, clr_idx 0..WORDS-1 ascending; after word WORDS-1 go to IDLE; busy=1; mem_valid ignored (master stalls).
REQ-018 IDLE: on a rising edge with mem_valid=1 the request SHALL be accepted at that same edge, as follows.
REQ-019 On accept, for each lane i with mem_wstrb[i]=1, lane i of word mem_addr SHALL be written at that edge.
REQ-020 On accept, the registered read data SHALL be the word content before the write (read-first).
REQ-021 On accept, the next state SHALL be WAIT if WAIT_STATES>0, else RESP.
REQ-022 WAIT: a down-counter loaded with WAIT_STATES on accept; go to RESP when the count reaches 1 after decrementing.
REQ-023 RESP: mem_ready=1 for exactly one cycle, then IDLE; mem_valid is ignored in RESP.
REQ-024 mem_ready SHALL rise exactly 1+WAIT_STATES cycles after the accepting edge.
REQ-025 Minimum request spacing SHALL be 2+WAIT_STATES cycles.
REQ-026 mem_rdata and mem_err SHALL hold their values from RESP until the next RESP; they are undefined to the master outside mem_ready.
REQ-027 Out of range (mem_addr >= WORDS, full ADDR_W compare): no lane written, mem_rdata=0, mem_err=1 in RESP.
REQ-028 In range: mem_err=0.
REQ-029 Memory content SHALL NOT be modified in WAIT or RESP.
REQ-030 Each lane SHALL be a separate byte-wide array so that it infers block RAM with a per-lane write enable.

Reset
REQ-031 While rst=1, the outputs SHALL be mem_ready=0, mem_err=0, mem_rdata=0, busy=CLEAR_ON_RESET; the wait counter SHALL be 0 and clr_idx SHALL be 0.
REQ-032 After rst is released, the state SHALL be CLEAR if CLEAR_ON_RESET=1, else IDLE.
REQ-033 Array contents SHALL NOT be reset; they persist across reset unless the clear sweep runs.
REQ-034 Reset asserted in WAIT or RESP SHALL abort the response (no mem_ready); a write already performed at the accepting edge SHALL remain.
REQ-035 Reset asserted mid-sweep SHALL restart the sweep at word 0.

Verification
REQ-036 Scenario (defaults): write addr 5, wstrb 4'hF, wdata 32'hDEADBEEF; ready one cycle after accept. Then read addr 5 -> rdata 32'hDEADBEEF, err 0.
REQ-037 Scenario (partial write): addr 5 holds DEADBEEF; write wstrb 4'b0101, wdata 32'h11223344 -> response rdata DEADBEEF (read-first). Next read -> 32'hDE22BE44.
REQ-038 Scenario (WAIT_STATES=3): read -> mem_ready exactly 4 cycles after accept, high for 1 cycle. Back-to-back requests -> spacing 5 cycles.
REQ-039 Scenario (range): read addr 256 with WORDS=256 -> rdata 0, err 1. Write addr 300 -> err 1, and a read of addr 300 mod 256 = 44 is unchanged.
REQ-040 Scenario (CLEAR_ON_RESET=1, WORDS=16): preload nonzero; reset -> busy high for exactly 16 cycles, request held pending gets ready only after busy falls. Reading word 15 -> 0.
REQ-041 Scenario (reset mid-operation): rst pulsed in WAIT -> no mem_ready, outputs 0. rst at clr_idx=7 -> sweep restarts, busy for the full 16 cycles.

Source files
------------

// File: rtl/picosoc_bram.sv
// Single-port byte-lane block RAM with a valid/ready slave port, optional wait
// states, an out-of-range error flag and an optional zeroing sweep after reset.
//
// state | meaning
// CLEAR | zeroing word clr_idx each cycle, requests stalled, busy high
// IDLE  | waiting for mem_valid; request accepted, written and read here
// WAIT  | counting down the configured wait states
// RESP  | mem_ready high for one cycle
module picosoc_bram #(
   parameter int WORDS          = 256,
   parameter int BYTES          = 4,
   parameter int ADDR_W         = 22,
   parameter int WAIT_STATES    = 0,
   parameter int CLEAR_ON_RESET = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_valid,
   input  logic [ADDR_W-1:0]    mem_addr,
   input  logic [BYTES-1:0]     mem_wstrb,
   input  logic [8*BYTES-1:0]   mem_wdata,
   output logic                 mem_ready,
   output logic [8*BYTES-1:0]   mem_rdata,
   output logic                 mem_err,
   output logic                 busy
);

   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [ADDR_W:0] WORDS_X = (ADDR_W+1)'(WORDS);
   localparam logic BUSY_RST = (CLEAR_ON_RESET != 0);

   typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

   state_t           state;
   logic [2:0]       wait_cnt;
   logic [IDX_W-1:0] clr_idx;
   logic             in_range;
   logic             accept;
   logic [IDX_W-1:0] acc_idx;
   logic [IDX_W-1:0] wr_idx;

   // Full-width compare so high address bits can never alias into the array.
   assign in_range = {1'b0, mem_addr} < WORDS_X;
   assign accept   = (state == IDLE) && mem_valid;
   assign acc_idx  = mem_addr[IDX_W-1:0];
   assign wr_idx   = (state == CLEAR) ? clr_idx : acc_idx;

   for (genvar i = 0; i < BYTES; i++) begin : g_lane
      logic [7:0] ram [WORDS];
      logic [7:0] rd_q;
      logic       we;

      assign we = !rst && ((state == CLEAR) || (accept && in_range && mem_wstrb[i]));

      always_ff @(posedge clk) begin
         if (we)
            ram[wr_idx] <= (state == CLEAR) ? 8'h00 : mem_wdata[8*i +: 8];
      end

      // Captured on the same edge as the write, so the old content is returned.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            rd_q <= '0;
         else if (accept)
            rd_q <= in_range ? ram[acc_idx] : 8'h00;
      end

      assign mem_rdata[8*i +: 8] = rd_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= BUSY_RST ? CLEAR : IDLE;
         busy      <= BUSY_RST;
         mem_ready <= 1'b0;
         mem_err   <= 1'b0;
         wait_cnt  <= '0;
         clr_idx   <= '0;
      end else begin
         mem_ready <= 1'b0;
         case (state)
            CLEAR: begin
               if (clr_idx == IDX_W'(WORDS - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  clr_idx <= clr_idx + 1'b1;
               end
            end
            IDLE: begin
               if (mem_valid) begin
                  mem_err  <= !in_range;
                  wait_cnt <= 3'(WAIT_STATES);
                  if (WAIT_STATES > 0) begin
                     state <= WAIT;
                  end else begin
                     state     <= RESP;
                     mem_ready <= 1'b1;
                  end
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt - 3'd1;
               if (wait_cnt == 3'd1) begin
                  state     <= RESP;
                  mem_ready <= 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
